// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the mycpu pipeline controller.
// Stage indices of the pipeline registers and the default stall bus width.
package pipe_ctrl_pkg;

    localparam int NSTAGE_DEF = 5;
    localparam int STALL_BUS  = NSTAGE_DEF + 1;

    localparam int PC_IDX  = 0;
    localparam int ID_IDX  = 1;
    localparam int EX_IDX  = 2;
    localparam int MEM_IDX = 3;
    localparam int WB_IDX  = 4;
    localparam int RF_IDX  = 5;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear (clr wins over inc).
// Ports: clk, inc (count this cycle), clr (zero the count), q (count, sticks at all ones).
module sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall/flush requests, tracks per-register valid bits,
// watches for hangs and counts stall cycles and accepted flushes.
// Ports: clk, rst (sync, active low), stallreq, fetch_valid, flush_req, flush_stage ->
//        flush_ack, stall, flush, stage_valid, hang_err, stall_cycles, flush_count.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE   = NSTAGE_DEF,
    parameter int SW       = $clog2(NSTAGE + 1),
    parameter int CNT_W    = 32,
    parameter int WDOG_MAX = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              fetch_valid,
    input  logic              flush_req,
    input  logic [SW-1:0]     flush_stage,
    output logic              flush_ack,
    output logic [NSTAGE:0]   stall,
    output logic [NSTAGE:0]   flush,
    output logic [NSTAGE-1:0] stage_valid,
    output logic              hang_err,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    logic [NSTAGE:0]   stall_raw;
    logic [NSTAGE:0]   kill;
    logic              older;
    logic              req_ok;
    logic              acc;
    logic [NSTAGE-1:0] valid_q;
    logic [NSTAGE:0]   vin;
    logic              hang_q;

    // stall_raw[j] is set when any stage at or beyond j holds, so the
    // oldest requester freezes itself and everything younger.
    always_comb begin
        stall_raw = '0;
        acc       = 1'b0;
        for (int j = NSTAGE; j >= 1; j--) begin
            acc          = acc | stallreq[j-1];
            stall_raw[j] = acc;
        end
        stall_raw[PC_IDX] = acc;
    end

    // A flush is blocked only by a hold from a stage older than f;
    // holds from stages <= f belong to instructions being killed.
    always_comb begin
        older = 1'b0;
        kill  = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (i >= int'(flush_stage)) older = older | stallreq[i];
        end
        for (int j = 1; j <= NSTAGE; j++) begin
            kill[j] = (j <= int'(flush_stage));
        end
        req_ok = flush_req && (flush_stage != '0) &&
                 (int'(flush_stage) <= NSTAGE);
    end

    always_comb begin
        flush_ack = 1'b0;
        stall     = '0;
        flush     = '0;
        if (!rst) begin
            flush = '1;
        end else if (req_ok && !older) begin
            flush_ack = 1'b1;
            flush     = kill;
        end else begin
            stall = stall_raw;
        end
    end

    assign vin = {valid_q, fetch_valid};

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            for (int j = 1; j <= NSTAGE; j++) begin
                if (flush[j])        valid_q[j-1] <= 1'b0;
                else if (stall[j])   valid_q[j-1] <= valid_q[j-1];
                else if (stall[j-1]) valid_q[j-1] <= 1'b0;
                else                 valid_q[j-1] <= vin[j-1];
            end
        end
    end

    assign stage_valid = valid_q;

    generate
        if (WDOG_MAX > 0) begin : g_wdog
            localparam int WD_W = $clog2(WDOG_MAX + 1);
            logic [WD_W-1:0] wd_q;

            // Count saturates at WDOG_MAX; the error is raised by the
            // same edge that brings the count to WDOG_MAX.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    wd_q   <= '0;
                    hang_q <= 1'b0;
                end else begin
                    if (!stall[PC_IDX]) begin
                        wd_q <= '0;
                    end else if (wd_q != WD_W'(WDOG_MAX)) begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                    if (stall[PC_IDX] && (wd_q >= WD_W'(WDOG_MAX - 1))) begin
                        hang_q <= 1'b1;
                    end
                end
            end
        end else begin : g_no_wdog
            assign hang_q = 1'b0;
        end
    endgenerate

    assign hang_err = hang_q;

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .inc (stall[PC_IDX]),
        .clr (!rst),
        .q   (stall_cycles)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .inc (flush_ack),
        .clr (!rst),
        .q   (flush_count)
    );

endmodule
